// File: rtl/sdram_bridge_pkg.sv
// Shared encodings and constants for the SDRAM prefetch bridge.
package sdram_bridge_pkg;

  localparam int unsigned ADDR_W        = 24;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned BURST_LEN     = 4;
  localparam int unsigned BEAT_W        = $clog2(BURST_LEN);
  localparam int unsigned STRIDE_NARROW = 4;
  localparam int unsigned STRIDE_WIDE   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_ACK
  } state_e;

  // Byte distance between consecutive prefetched words for a stride select.
  function automatic logic [ADDR_W-1:0] stride_bytes(input logic step);
    return step ? ADDR_W'(STRIDE_WIDE) : ADDR_W'(STRIDE_NARROW);
  endfunction

endpackage

// File: rtl/sdram_prefetch_line.sv
// One prefetched line: four words, base/stride tag, valid bit and hit lookup.
module sdram_prefetch_line
  import sdram_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_inval,
  input  logic              i_wr_en,
  input  logic [BEAT_W-1:0] i_wr_idx,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_fill_done,
  input  logic [ADDR_W-1:0] i_fill_tag,
  input  logic              i_fill_step,
  input  logic [ADDR_W-1:0] i_lk_addr,
  input  logic              i_lk_step,
  output logic              o_hit_c,
  output logic [DATA_W-1:0] o_hit_data_c,
  output logic [DATA_W-1:0] o_word0
);

  logic [DATA_W-1:0] r_words [BURST_LEN];
  logic [ADDR_W-1:0] r_tag;
  logic              r_step;
  logic              r_valid;
  logic [ADDR_W-1:0] w_stride;

  assign w_stride = stride_bytes(r_step);
  assign o_word0  = r_words[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_step  <= 1'b0;
      for (int i = 0; i < BURST_LEN; i++) r_words[i] <= '0;
    end else begin
      if (i_wr_en) r_words[i_wr_idx] <= i_wr_data;
      if (i_inval) begin
        r_valid <= 1'b0;
      end else if (i_fill_done) begin
        r_valid <= 1'b1;
        r_tag   <= i_fill_tag;
        r_step  <= i_fill_step;
      end
    end
  end

  // Word k covers tag + k*stride; the stride select must also match.
  always_comb begin
    o_hit_c      = 1'b0;
    o_hit_data_c = '0;
    for (int k = 0; k < BURST_LEN; k++) begin
      if (r_valid && (r_step == i_lk_step) &&
          (i_lk_addr == r_tag + ADDR_W'(k) * w_stride)) begin
        o_hit_c      = 1'b1;
        o_hit_data_c = r_words[k];
      end
    end
  end

endmodule

// File: rtl/sdram_prefetch_bridge.sv
// Wishbone slave to SDRAM controller bridge with a one-line read prefetch buffer.
// Buffer present only when SDRAM_PREFETCH_BUF_EN is defined; otherwise reads always miss.
module sdram_prefetch_bridge
  import sdram_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFF80_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic              ctrl_rw,
  output logic [DATA_W-1:0] ctrl_wdata,
  output logic              ctrl_in_valid,
  input  logic              ctrl_busy,
  input  logic [DATA_W-1:0] ctrl_rdata,
  input  logic              ctrl_out_valid,
  output logic              ctrl_prefetch_step,
  input  logic              cfg_step
);

  state_e            r_state, w_state_nxt;
  logic              r_after_ack;
  logic              r_live;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic              w_sel, w_accept, w_issue, w_beat, w_last, w_ack_ok;
  logic              w_hit;
  logic [DATA_W-1:0] w_hit_data, w_fill_data;
  logic              w_unused_sel;

  // No byte mask on the controller side: every write is a full word.
  assign w_unused_sel = ^wbs_sel_i;

  assign w_sel    = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign w_accept = (r_state == ST_IDLE) & w_sel & ~r_after_ack;
  assign w_issue  = ((r_state == ST_RD_REQ) | (r_state == ST_WR_REQ)) & wbs_cyc_i & ~ctrl_busy;
  assign w_beat   = (r_state == ST_RD_WAIT) & ctrl_out_valid;
  assign w_last   = w_beat & (r_beat_cnt == BEAT_W'(BURST_LEN - 1));
  assign w_ack_ok = r_live & wbs_cyc_i;

`ifdef SDRAM_PREFETCH_BUF_EN
  sdram_prefetch_line u_line (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_inval      (w_issue),
    .i_wr_en      (w_beat),
    .i_wr_idx     (r_beat_cnt),
    .i_wr_data    (ctrl_rdata),
    .i_fill_done  (w_last),
    .i_fill_tag   (ctrl_addr),
    .i_fill_step  (ctrl_prefetch_step),
    .i_lk_addr    (wbs_adr_i[ADDR_W-1:0]),
    .i_lk_step    (cfg_step),
    .o_hit_c      (w_hit),
    .o_hit_data_c (w_hit_data),
    .o_word0      (w_fill_data)
  );
`else
  logic [DATA_W-1:0] r_beat0;

  // Keep beat 0 only; beats 1..3 are drained by the beat counter.
  always_ff @(posedge clk) begin
    if (!rst_n)                           r_beat0 <= '0;
    else if (w_beat && (r_beat_cnt == '0)) r_beat0 <= ctrl_rdata;
  end

  assign w_hit       = 1'b0;
  assign w_hit_data  = '0;
  assign w_fill_data = r_beat0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (wbs_we_i)   w_state_nxt = ST_WR_REQ;
          else if (w_hit) w_state_nxt = ST_HIT;
          else            w_state_nxt = ST_RD_REQ;
        end
      end
      ST_HIT:     w_state_nxt = ST_ACK;
      // A request not yet issued is abandoned if the master drops the cycle.
      ST_RD_REQ: begin
        if (!wbs_cyc_i)     w_state_nxt = ST_IDLE;
        else if (w_issue)   w_state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: if (w_last) w_state_nxt = ST_ACK;
      ST_WR_REQ: begin
        if (!wbs_cyc_i)     w_state_nxt = ST_IDLE;
        else if (w_issue)   w_state_nxt = ST_ACK;
      end
      ST_ACK:     w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered bus and controller outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbs_ack_o          <= 1'b0;
      wbs_dat_o          <= '0;
      ctrl_addr          <= '0;
      ctrl_rw            <= 1'b0;
      ctrl_wdata         <= '0;
      ctrl_in_valid      <= 1'b0;
      ctrl_prefetch_step <= 1'b0;
      r_beat_cnt         <= '0;
      r_after_ack        <= 1'b0;
      r_live             <= 1'b0;
    end else begin
      wbs_ack_o     <= (w_state_nxt == ST_ACK) & w_ack_ok;
      ctrl_in_valid <= w_issue;
      r_after_ack   <= (r_state == ST_ACK);
      r_live        <= w_accept | (r_live & wbs_cyc_i);
      if (r_state != ST_RD_WAIT) r_beat_cnt <= '0;
      else if (w_beat)           r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
      if (w_accept) begin
        ctrl_addr <= wbs_adr_i[ADDR_W-1:0];
        ctrl_rw   <= wbs_we_i;
        if (wbs_we_i) ctrl_wdata         <= wbs_dat_i;
        else          ctrl_prefetch_step <= cfg_step;
        if (!wbs_we_i && w_hit) wbs_dat_o <= w_hit_data;
      end
      if (w_last) wbs_dat_o <= w_fill_data;
    end
  end

endmodule

// File: tb/tb_sdram_prefetch_bridge.sv
// Randomized self-checking bench for sdram_prefetch_bridge with a reference memory and line model.
module tb_sdram_prefetch_bridge;

`ifdef SDRAM_PREFETCH_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i;
  logic        ack;
  logic [31:0] dat_o;
  logic [23:0] ctrl_addr;
  logic        ctrl_rw;
  logic [31:0] ctrl_wdata;
  logic        ctrl_in_valid;
  logic        ctrl_busy;
  logic [31:0] ctrl_rdata;
  logic        ctrl_out_valid;
  logic        ctrl_prefetch_step;
  logic        cfg_step;

  always #5 clk = ~clk;

  sdram_prefetch_bridge dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .wbs_cyc_i          (cyc),
    .wbs_stb_i          (stb),
    .wbs_we_i           (we),
    .wbs_sel_i          (sel),
    .wbs_adr_i          (adr),
    .wbs_dat_i          (dat_i),
    .wbs_ack_o          (ack),
    .wbs_dat_o          (dat_o),
    .ctrl_addr          (ctrl_addr),
    .ctrl_rw            (ctrl_rw),
    .ctrl_wdata         (ctrl_wdata),
    .ctrl_in_valid      (ctrl_in_valid),
    .ctrl_busy          (ctrl_busy),
    .ctrl_rdata         (ctrl_rdata),
    .ctrl_out_valid     (ctrl_out_valid),
    .ctrl_prefetch_step (ctrl_prefetch_step),
    .cfg_step           (cfg_step)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Controller memory (fed by what the DUT writes) and the bench's own expected memory.
  logic [31:0] ctrl_mem [logic [23:0]];
  logic [31:0] exp_mem  [logic [23:0]];
  bit          line_map [logic [23:0]];
  logic        line_step = 1'b0;

  function automatic logic [31:0] dflt(input logic [23:0] a);
    return {8'hC3, a} ^ 32'h0055_AA00;
  endfunction
  function automatic logic [31:0] ctrl_rd(input logic [23:0] a);
    return ctrl_mem.exists(a) ? ctrl_mem[a] : dflt(a);
  endfunction
  function automatic logic [31:0] exp_rd(input logic [23:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : dflt(a);
  endfunction

  task automatic preload(input logic [23:0] a, input logic [31:0] v);
    ctrl_mem[a] = v;
    exp_mem[a]  = v;
  endtask

  // SDRAM controller model: records each request, returns 4 beats with random gaps.
  logic [31:0] beat_q [$];
  int          n_pulse = 0;
  int          n_beats = 0;
  logic [23:0] last_addr = '0;
  logic        last_rw = 1'b0, last_step = 1'b0;
  logic [31:0] last_wdata = '0;
  bit          busy_force = 1'b0, rand_busy = 1'b0;

  initial begin
    ctrl_busy = 1'b0; ctrl_out_valid = 1'b0; ctrl_rdata = '0;
    forever begin
      @(negedge clk);
      if (beat_q.size() > 0 && $urandom_range(3) != 0) begin
        ctrl_rdata = beat_q.pop_front(); ctrl_out_valid = 1'b1; n_beats++;
      end else begin
        ctrl_rdata = $urandom; ctrl_out_valid = 1'b0;
      end
      if (ctrl_in_valid) begin
        n_pulse++;
        last_addr = ctrl_addr; last_rw = ctrl_rw; last_step = ctrl_prefetch_step; last_wdata = ctrl_wdata;
        if (ctrl_rw) ctrl_mem[ctrl_addr] = ctrl_wdata;
        else for (int k = 0; k < 4; k++)
          beat_q.push_back(ctrl_rd(ctrl_addr + 24'(k * (ctrl_prefetch_step ? 16 : 4))));
      end
      ctrl_busy = busy_force | (rand_busy & ($urandom_range(3) == 0));
    end
  end

  task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic stp, input int hold_busy,
                          output logic [31:0] rd, output int lat, output int pulses);
    int p0, viol;
    p0 = n_pulse;
    cfg_step = stp; we = w; adr = a; dat_i = d; sel = s; cyc = 1'b1; stb = 1'b1;
    lat = 0;
    if (hold_busy > 0) begin
      busy_force = 1'b1; viol = 0;
      repeat (hold_busy) begin
        @(posedge clk); #1; lat++;
        if (ack) viol++;
      end
      check_eq("busy_no_ack", viol, 0);
      check_eq("busy_no_pulse", n_pulse - p0, 0);
      busy_force = 1'b0;
    end
    do begin
      @(posedge clk); #1; lat++;
    end while (!ack && lat < 300);
    check_eq("ack_seen", ack, 1);
    rd = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk); #1;
    pulses = n_pulse - p0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // One transaction checked against the memory/line reference model.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic stp, input int hold_busy);
    logic [31:0] rd;
    int          lat, pulses;
    logic [23:0] a24;
    bit          hit;
    a24 = a[23:0];
    hit = BUF_EN && !w && line_map.exists(a24) && (line_step == stp);
    bus_xfer(w, a, d, s, stp, hold_busy, rd, lat, pulses);
    if (w) begin
      check_eq("wr_pulses", pulses, 1);
      check_eq("wr_rw", last_rw, 1);
      check_eq("wr_addr", last_addr, a24);
      check_eq("wr_data", last_wdata, d);
      exp_mem[a24] = d;
      line_map.delete();
    end else begin
      check_eq("rd_data", rd, exp_rd(a24));
      if (hit) begin
        check_eq("hit_lat", lat, 2);
        check_eq("hit_pulses", pulses, 0);
      end else begin
        check_eq("miss_pulses", pulses, 1);
        check_eq("miss_addr", last_addr, a24);
        check_eq("miss_step", last_step, stp);
        check_eq("miss_rw", last_rw, 0);
        if (BUF_EN) begin
          line_map.delete();
          for (int k = 0; k < 4; k++) line_map[a24 + 24'(k * (stp ? 16 : 4))] = 1'b1;
          line_step = stp;
        end
      end
    end
  endtask

  task automatic wait_quiet(input string tag);
    int t, quiet, viol;
    t = 0; quiet = 0; viol = 0;
    while (quiet < 4 && t < 200) begin
      @(posedge clk); #1; t++;
      if (ack) viol++;
      quiet = (beat_q.size() == 0) ? quiet + 1 : 0;
    end
    check_eq(tag, viol, 0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, t, viol, first, second;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'hF;
    adr = '0; dat_i = '0; cfg_step = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ack", ack, 0);
    check_eq("rst_dat", dat_o, 0);
    check_eq("rst_in_valid", ctrl_in_valid, 0);
    check_eq("rst_addr", ctrl_addr, 0);
    check_eq("rst_rw", ctrl_rw, 0);
    check_eq("rst_wdata", ctrl_wdata, 0);
    check_eq("rst_step", ctrl_prefetch_step, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Line fill with stride 4, then sequential hits.
    preload(24'h10, 32'hAAAA_0001); preload(24'h14, 32'hBBBB_0002);
    preload(24'h18, 32'hCCCC_0003); preload(24'h1C, 32'hDDDD_0004);
    txn(1'b0, 32'h3800_0010, '0, 4'hF, 1'b0, 0);
    txn(1'b0, 32'h3800_0014, '0, 4'hF, 1'b0, 0);
    txn(1'b0, 32'h3800_0018, '0, 4'hF, 1'b0, 0);
    txn(1'b0, 32'h3800_001C, '0, 4'hF, 1'b0, 0);

    // Stride 16 line, last-word hit, off-stride miss.
    txn(1'b0, 32'h3800_0000, '0, 4'hF, 1'b1, 0);
    txn(1'b0, 32'h3800_0030, '0, 4'hF, 1'b1, 0);
    txn(1'b0, 32'h3800_0004, '0, 4'hF, 1'b1, 0);

    // Partial-select write invalidates the line and is written as a full word.
    txn(1'b0, 32'h3800_0010, '0, 4'hF, 1'b0, 0);
    txn(1'b1, 32'h3800_0014, 32'hDEAD_BEEF, 4'h3, 1'b0, 0);
    txn(1'b0, 32'h3800_0014, '0, 4'hF, 1'b0, 0);

    // Controller busy for 20 cycles during a miss.
    txn(1'b0, 32'h3800_0044, '0, 4'hF, 1'b0, 20);

    // Decode boundaries: last selected word, first unselected address.
    txn(1'b0, 32'h387F_FFFC, '0, 4'hF, 1'b0, 0);
    p0 = n_pulse; viol = 0;
    adr = 32'h3880_0000; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (ack) viol++;
    end
    cyc = 1'b0; stb = 1'b0;
    check_eq("unsel_ack", viol, 0);
    check_eq("unsel_pulses", n_pulse - p0, 0);
    @(posedge clk); #1;

    // Strobe held through the ack: one-cycle ack, one blocked cycle, then re-accept.
    p0 = n_pulse; first = -1; second = -1;
    cfg_step = 1'b0; we = 1'b1; adr = 32'h3800_0020; dat_i = 32'h1234_5678; sel = 4'hF;
    cyc = 1'b1; stb = 1'b1;
    for (int c = 1; c <= 40 && second < 0; c++) begin
      @(posedge clk); #1;
      if (ack) begin
        if (first < 0) first = c;
        else second = c;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reack_first_lat", first, 2);
    check_eq("reack_gap", second - first, 4);
    check_eq("reack_pulses", n_pulse - p0, 2);
    exp_mem[24'h20] = 32'h1234_5678;
    line_map.delete();

    // Randomized mix with random controller back-pressure.
    rand_busy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      logic w;
      w = ($urandom_range(4) == 0);
      txn(w, 32'h3800_0000 + 32'(4 * $urandom_range(23)), $urandom, 4'($urandom_range(15)),
          1'($urandom_range(1)), 0);
    end
    rand_busy = 1'b0;

    // Reset after beat 2 of a fill: partial line discarded, stray beats ignored.
    txn(1'b1, 32'h3800_0090, 32'h0BAD_F00D, 4'hF, 1'b0, 0);
    p0 = n_beats; t = 0;
    cfg_step = 1'b0; we = 1'b0; adr = 32'h3800_0040; cyc = 1'b1; stb = 1'b1;
    while (n_beats < p0 + 3 && t < 300) begin
      @(posedge clk); #1; t++;
    end
    check_eq("rst_fill_beats", n_beats - p0, 3);
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("midrst_ack", ack, 0);
    check_eq("midrst_dat", dat_o, 0);
    check_eq("midrst_addr", ctrl_addr, 0);
    line_map.delete();
    wait_quiet("stray_beat_ack");
    txn(1'b0, 32'h3800_0040, '0, 4'hF, 1'b0, 0);

    // Cycle dropped after issue: fill completes, ack is suppressed.
    p0 = n_pulse; t = 0;
    cfg_step = 1'b0; we = 1'b0; adr = 32'h3800_0080; cyc = 1'b1; stb = 1'b1;
    while (n_pulse == p0 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    check_eq("drop_issued", n_pulse - p0, 1);
    cyc = 1'b0; stb = 1'b0;
    wait_quiet("drop_no_ack");
    if (BUF_EN) begin
      line_map.delete();
      for (int k = 0; k < 4; k++) line_map[24'h80 + 24'(k * 4)] = 1'b1;
      line_step = 1'b0;
    end
    txn(1'b0, 32'h3800_0084, '0, 4'hF, 1'b0, 0);

    // Same address twice back to back.
    txn(1'b0, 32'h3800_0050, '0, 4'hF, 1'b0, 0);
    txn(1'b0, 32'h3800_0050, '0, 4'hF, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
